// File: rtl/cc_pkg.sv
// cc_pkg: shared types and puncture tables for the convolutional-code block sequencer
package cc_pkg;
  typedef enum logic [1:0] {RATE_1_2, RATE_2_3, RATE_3_4, RATE_5_6} cc_rate_t;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL, S_DONE} state_t;
  localparam int CC_K = 7;
  localparam int PH_W = 3;
  localparam logic [PH_W-1:0] PERIOD [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
  // keep mask per (rate, phase) as {keep Y, keep X}; entries past the period are unused
  localparam logic [1:0] KEEP [4][5] = '{
    '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11},
    '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11},
    '{2'b11, 2'b10, 2'b01, 2'b11, 2'b11},
    '{2'b11, 2'b10, 2'b01, 2'b10, 2'b01}};
endpackage

// File: rtl/cc_punct_gen.sv
// cc_punct_gen: puncture phase counter with rate-indexed keep-mask lookup
module cc_punct_gen
  import cc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       adv_i,
  input  cc_rate_t   rate_i,
  output logic [1:0] keep_o
);
  logic [PH_W-1:0] phase_q, phase_d;
  always_comb begin
    phase_d = clear_i ? '0 : !adv_i ? phase_q : (phase_q == PERIOD[rate_i] - 1'b1) ? '0 : phase_q + 1'b1;
    keep_o = KEEP[rate_i][phase_q];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) phase_q <= '0;
    else phase_q <= phase_d;
endmodule

// File: rtl/cc_seq.sv
// cc_seq: FEC block sequencer (data, zero tail, puncture mask); CC_BLK_CNT_EN enables blk_cnt
module cc_seq
  import cc_pkg::*;
#(
  parameter int LEN_W    = 12,
  parameter int TAIL_LEN = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] blk_bits,
  input  logic [1:0]       cc_rate,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             enc_valid,
  output logic             enc_bit,
  output logic             enc_last,
  output logic [1:0]       punct_keep,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      blk_cnt
);
  localparam int TW = $clog2(TAIL_LEN + 1);
  state_t state_q, state_d;
  cc_rate_t rate_q, rate_d;
  logic [LEN_W-1:0] n_q, n_d, cnt_q, cnt_d;
  logic [TW-1:0] tc_q, tc_d;
  logic ev_q, ev_d, eb_q, eb_d, el_q, el_d, err_q, err_d, accept;
  logic [1:0] keep, keep_q;
  assign in_ready   = state_q == S_DATA;
  assign busy       = state_q != S_IDLE;
  assign done       = state_q == S_DONE;
  assign enc_valid  = ev_q;
  assign enc_bit    = eb_q;
  assign enc_last   = el_q;
  assign punct_keep = keep_q;
  assign err        = err_q;
  always_comb begin
    accept = start && blk_bits != '0 && (state_q == S_IDLE || state_q == S_DONE);
    state_d = state_q;
    rate_d = rate_q;
    n_d = n_q;
    cnt_d = cnt_q;
    tc_d = tc_q;
    ev_d = 1'b0;
    eb_d = 1'b0;
    el_d = 1'b0;
    err_d = start && !accept;
    case (state_q)
      S_DATA: if (in_valid) begin
        ev_d = 1'b1;
        eb_d = in_bit;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == n_q - 1'b1) state_d = S_TAIL;
      end
      // one extra TAIL cycle lets the last registered tail bit show before DONE
      S_TAIL: if (tc_q == TW'(TAIL_LEN)) state_d = S_DONE;
      else begin
        ev_d = 1'b1;
        el_d = tc_q == TW'(TAIL_LEN - 1);
        tc_d = tc_q + 1'b1;
      end
      default: begin
        state_d = accept ? S_DATA : S_IDLE;
        rate_d = accept ? cc_rate_t'(cc_rate) : rate_q;
        n_d = accept ? blk_bits : n_q;
        cnt_d = '0;
        tc_d = '0;
      end
    endcase
  end
  cc_punct_gen u_punct (
    .clk    (clk),
    .rst    (reset),
    .clear_i(accept),
    .adv_i  (ev_d),
    .rate_i (rate_q),
    .keep_o (keep)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      rate_q <= RATE_1_2;
      n_q <= '0;
      cnt_q <= '0;
      tc_q <= '0;
      ev_q <= 1'b0;
      eb_q <= 1'b0;
      el_q <= 1'b0;
      err_q <= 1'b0;
      keep_q <= 2'b00;
    end else begin
      state_q <= state_d;
      rate_q <= rate_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      tc_q <= tc_d;
      ev_q <= ev_d;
      eb_q <= eb_d;
      el_q <= el_d;
      err_q <= err_d;
      keep_q <= ev_d ? keep : 2'b00;
    end
`ifdef CC_BLK_CNT_EN
  logic [15:0] blk_cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) blk_cnt_q <= '0;
    else if (state_q == S_DONE) blk_cnt_q <= blk_cnt_q + 1'b1;
  assign blk_cnt = blk_cnt_q;
`else
  assign blk_cnt = '0;
`endif
endmodule

// File: tb/tb_cc_seq.sv
// tb_cc_seq: randomized and directed checks of cc_seq against a block-level reference model
module tb_cc_seq;
  localparam int TAIL = 6;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_bit = 1'b0;
  logic [11:0] blk_bits = '0;
  logic [1:0] cc_rate = '0;
  logic in_ready, enc_valid, enc_bit, enc_last, busy, done, err;
  logic [1:0] punct_keep;
  logic [15:0] blk_cnt;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  cc_seq dut (
    .clk(clk), .reset(reset), .start(start), .blk_bits(blk_bits), .cc_rate(cc_rate),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .enc_valid(enc_valid),
    .enc_bit(enc_bit), .enc_last(enc_last), .punct_keep(punct_keep), .busy(busy),
    .done(done), .err(err), .blk_cnt(blk_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // puncture masks written as per-step X/Y keep strings (bit j = step j)
  int per [4] = '{1, 2, 3, 5};
  logic [4:0] xm [4] = '{5'b00001, 5'b00001, 5'b00101, 5'b10101};
  logic [4:0] ym [4] = '{5'b00001, 5'b00011, 5'b00011, 5'b01011};

  // model: mode 0 idle, 1 taking data, 2 flushing tail, 3 block finished
  int m_mode = 0, m_left = 0, m_tail = 0, m_k = 0, m_rate = 0;
  logic [15:0] m_cnt = '0;
  logic e_valid = 0, e_bit = 0, e_last = 0, e_err = 0;
  logic [1:0] e_keep = '0;

  initial forever begin
    @(posedge clk or posedge reset);
    e_valid = 0; e_bit = 0; e_last = 0; e_err = 0; e_keep = '0;
    if (reset) begin
      m_mode = 0; m_left = 0; m_tail = 0; m_k = 0; m_cnt = '0;
    end else if (m_mode == 1 || m_mode == 2) begin
      e_err = start;
      if (m_mode == 1 && in_valid) begin
        e_valid = 1; e_bit = in_bit;
        m_left--;
        if (m_left == 0) begin m_mode = 2; m_tail = 0; end
      end else if (m_mode == 2) begin
        if (m_tail < TAIL) begin
          e_valid = 1; e_last = (m_tail == TAIL - 1); m_tail++;
        end else m_mode = 3;
      end
      if (e_valid) begin
        e_keep = {ym[m_rate][m_k % per[m_rate]], xm[m_rate][m_k % per[m_rate]]};
        m_k++;
      end
    end else begin
      if (m_mode == 3) m_cnt++;
      m_mode = 0;
      if (start && blk_bits != 0) begin
        m_mode = 1; m_left = int'(blk_bits); m_rate = int'(cc_rate); m_k = 0;
      end else e_err = start;
    end
  end

  logic lg_bit [$];
  logic lg_last [$];
  logic [1:0] lg_keep [$];
  int cyc_n = 0, last_at = 0, done_at = 0, done_n = 0;

  initial forever begin
    @(negedge clk);
    cyc_n++;
    chk("in_ready", in_ready, m_mode == 1);
    chk("enc_valid", enc_valid, e_valid);
    if (e_valid) chk("enc_bit", enc_bit, e_bit);
    chk("enc_last", enc_last, e_last);
    chk("punct_keep", punct_keep, e_keep);
    chk("busy", busy, m_mode != 0);
    chk("done", done, m_mode == 3);
    chk("err", err, e_err);
`ifdef CC_BLK_CNT_EN
    chk("blk_cnt", blk_cnt, m_cnt);
`else
    chk("blk_cnt", blk_cnt, 0);
`endif
    if (enc_valid) begin lg_bit.push_back(enc_bit); lg_keep.push_back(punct_keep); lg_last.push_back(enc_last); end
    if (enc_last) last_at = cyc_n;
    if (done) begin done_at = cyc_n; done_n++; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int n, input int rate, input int gap, input logic [63:0] bits, input int sp_at);
    int g, w;
    start = 1; blk_bits = 12'(n); cc_rate = 2'(rate);
    tick();
    start = 0;
    chk("start_busy", busy, 1'b1);
    chk("start_ready", in_ready, 1'b1);
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_bit = bits[i];
      if (i == sp_at) begin start = 1; blk_bits = 12'd5; end
      tick();
      in_valid = 0;
      if (i == sp_at) begin start = 0; chk("err_in_data", err, 1'b1); end
      g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
      repeat (g) tick();
    end
    w = 0;
    while (!done && w < 60) begin tick(); w++; end
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, n, dn0;
    logic [31:0] v, lv, kv;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", enc_valid, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    tick();

    // 1: rate 1/2, N=4, bits 1,0,1,1
    b0 = lg_bit.size();
    run_block(4, 0, 0, 64'b1101, -1);
    tick();
    n = lg_bit.size() - b0;
    v = '0; lv = '0; kv = '0;
    for (int i = 0; i < n && i < 16; i++) begin
      v[i] = lg_bit[b0+i]; lv[i] = lg_last[b0+i]; kv[2*i +: 2] = lg_keep[b0+i];
    end
    chk("t1_count", n, 10);
    chk("t1_bits", v, 32'h0000000D);
    chk("t1_last", lv, 32'h00000200);
    chk("t1_keep", kv, 32'h000FFFFF);
    chk("t1_done_lat", done_at - last_at, 1);

    // 2: rate 5/6, N=10
    b0 = lg_bit.size();
    run_block(10, 3, 0, {$urandom, $urandom}, -1);
    tick();
    n = lg_bit.size() - b0;
    kv = '0;
    for (int i = 0; i < n && i < 16; i++) kv[2*i +: 2] = lg_keep[b0+i];
    chk("t2_count", n, 16);
    chk("t2_keep", kv, 32'hD9B66D9B);

    // 3: rate 2/3, N=3 with 2-cycle gaps
    b0 = lg_bit.size();
    run_block(3, 1, 2, {$urandom, $urandom}, -1);
    tick();
    n = lg_bit.size() - b0;
    kv = '0;
    for (int i = 0; i < n && i < 16; i++) kv[2*i +: 2] = lg_keep[b0+i];
    chk("t3_count", n, 9);
    chk("t3_keep", kv, 32'h0003BBBB);

    // 4: illegal starts
    start = 1; blk_bits = 0;
    tick();
    start = 0;
    chk("t4_err_idle", err, 1);
    chk("t4_busy_idle", busy, 0);
    tick();
    b0 = lg_bit.size();
    run_block(8, 2, 0, {$urandom, $urandom}, 3);
    tick();
    chk("t4_count", lg_bit.size() - b0, 14);

    // 5: back-to-back blocks
    b0 = lg_bit.size();
    run_block(5, 1, 0, {$urandom, $urandom}, -1);
    chk("t5_in_done", done, 1);
    run_block(6, 2, 0, {$urandom, $urandom}, -1);
    tick();
    chk("t5_count", lg_bit.size() - b0, 23);

    // 6: reset mid-block, then three full blocks
    start = 1; blk_bits = 12'd20; cc_rate = 2'($urandom_range(0, 3));
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin in_valid = 1; in_bit = 1'($urandom); tick(); end
    in_valid = 1; in_bit = 1;
    dn0 = done_n;
    reset = 1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_valid", enc_valid, 0);
    chk("t6_ready", in_ready, 0);
    tick(); tick();
    in_valid = 0; reset = 0;
    tick(); tick();
    chk("t6_no_done", done_n - dn0, 0);
    chk("t6_cnt_clr", blk_cnt, 0);
    for (int k = 0; k < 3; k++) run_block(int'($urandom_range(1, 12)), int'($urandom_range(0, 3)), -1, {$urandom, $urandom}, -1);
    tick();
`ifdef CC_BLK_CNT_EN
    chk("t6_blk_cnt", blk_cnt, 3);
`else
    chk("t6_blk_cnt", blk_cnt, 0);
`endif

    // randomized blocks, idle gaps, back-to-back and stray starts
    for (int r = 0; r < 40; r++) begin
      n = int'($urandom_range(1, 24));
      repeat ($urandom_range(0, 2)) tick();
      b0 = lg_bit.size();
      run_block(n, int'($urandom_range(0, 3)), -1, {$urandom, $urandom},
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1);
      chk("rnd_count", lg_bit.size() - b0, n + TAIL);
    end
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
